// File: rtl/i2c_seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_controller
// Function : Command-ROM driven I2C configuration sequencer. Walks WRITE /
//            DELAY / END entries, drives a byte-level I2C engine through a
//            send/done handshake, retries NACKed writes a bounded number of
//            times, supports abort, and reports failed entries.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_seq_controller #(
  parameter int NBYTES_MAX  = 4,
  parameter int NTRANS      = 64,
  parameter int RETRIES     = 3,
  parameter int DELAY_W     = 16,
  parameter int ROM_LAT     = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             start_1cc_i,
  input  logic                             abort_i,
  output logic [$clog2(NTRANS)-1:0]        rom_addr_o,
  input  logic [8+8*NBYTES_MAX-1:0]        rom_data_i,
  output logic                             eng_send_o,
  output logic [$clog2(NBYTES_MAX+1)-1:0]  eng_nbytes_o,
  output logic [8*NBYTES_MAX-1:0]          eng_data_o,
  input  logic                             eng_ready_i,
  input  logic                             eng_done_i,
  input  logic [NBYTES_MAX-1:0]            eng_ack_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [$clog2(NTRANS)-1:0]        fail_idx_o,
  output logic [7:0]                       fail_cnt_o
);

  localparam int AW  = $clog2(NTRANS);
  localparam int NBW = $clog2(NBYTES_MAX + 1);
  localparam int PW  = 8 * NBYTES_MAX;
  localparam int RW  = $clog2(RETRIES + 2);

  localparam logic [AW-1:0]      c_LAST_ADDR = AW'(NTRANS - 1);
  localparam logic [RW-1:0]      c_RETRIES   = RW'(RETRIES);
  localparam logic [3:0]         c_NBMAX     = 4'(NBYTES_MAX);
  localparam logic [1:0]         c_LAT_LAST  = 2'(ROM_LAT - 1);
  localparam logic [DELAY_W-1:0] c_DLY_ONE   = DELAY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_SEND   = 3'd3,
    S_WAIT   = 3'd4,
    S_DLY    = 3'd5,
    S_NEXT   = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  state_t               r_state;
  logic [1:0]           r_lat;
  logic [RW-1:0]        r_retry;
  logic [DELAY_W-1:0]   r_dly;
  logic                 r_abort_pend;

  logic [7:0]           w_ctrl;
  logic [1:0]           w_op;
  logic [3:0]           w_nb;
  logic [PW-1:0]        w_payload;
  logic                 w_nb_ok;
  logic                 w_ack_ok;
  logic [7:0]           w_fail_cnt_inc;
  logic                 w_unused;

  assign w_ctrl         = rom_data_i[PW+7:PW];
  assign w_op           = w_ctrl[7:6];
  assign w_nb           = w_ctrl[3:0];
  assign w_payload      = rom_data_i[PW-1:0];
  assign w_nb_ok        = (w_nb != 4'd0) && (w_nb <= c_NBMAX);
  assign w_fail_cnt_inc = (fail_cnt_o == 8'hFF) ? 8'hFF : fail_cnt_o + 8'd1;
  assign w_unused       = ^w_ctrl[5:4];

  // Transfer succeeds when every byte actually sent was ACKed; flags above nbytes are ignored
  always_comb begin
    w_ack_ok = 1'b1;
    for (int i = 0; i < NBYTES_MAX; i++) begin
      if ((NBW'(i) < eng_nbytes_o) && !eng_ack_i[i]) begin
        w_ack_ok = 1'b0;
      end
    end
  end

  // Sequencer FSM with registered outputs; the failure bookkeeping is repeated at each failure site
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_lat        <= 2'd0;
      r_retry      <= '0;
      r_dly        <= '0;
      r_abort_pend <= 1'b0;
      rom_addr_o   <= '0;
      eng_send_o   <= 1'b0;
      eng_nbytes_o <= '0;
      eng_data_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      fail_idx_o   <= '0;
      fail_cnt_o   <= 8'd0;
    end else begin
      eng_send_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_1cc_i) begin
            rom_addr_o   <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            fail_cnt_o   <= 8'd0;
            fail_idx_o   <= '0;
            busy_o       <= 1'b1;
            r_lat        <= 2'd0;
            r_retry      <= '0;
            r_abort_pend <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort_i) begin
            err_o   <= 1'b1;
            r_state <= S_FIN;
          end else if (r_lat == c_LAT_LAST) begin
            r_lat   <= 2'd0;
            r_state <= S_DECODE;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_DECODE: begin
          if (abort_i) begin
            err_o   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            case (w_op)
              2'b00: begin
                if (w_nb_ok) begin
                  eng_nbytes_o <= NBW'(w_nb);
                  eng_data_o   <= w_payload;
                  r_state      <= S_SEND;
                end else begin
                  err_o      <= 1'b1;
                  fail_idx_o <= rom_addr_o;
                  fail_cnt_o <= w_fail_cnt_inc;
                  r_retry    <= '0;
                  r_state    <= (STOP_ON_ERR != 0) ? S_FIN : S_NEXT;
                end
              end
              2'b01: begin
                r_dly   <= w_payload[DELAY_W-1:0];
                r_state <= S_DLY;
              end
              2'b10: r_state <= S_FIN;
              default: begin
                // An illegal opcode means the ROM image is corrupt: never continue past it
                err_o      <= 1'b1;
                fail_idx_o <= rom_addr_o;
                fail_cnt_o <= w_fail_cnt_inc;
                r_retry    <= '0;
                r_state    <= S_FIN;
              end
            endcase
          end
        end
        S_SEND: begin
          if (abort_i) begin
            err_o   <= 1'b1;
            r_state <= S_FIN;
          end else if (eng_ready_i) begin
            eng_send_o <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Abort cannot cut a transfer short; remember it until the engine reports done
          if (abort_i) begin
            r_abort_pend <= 1'b1;
          end
          if (eng_done_i) begin
            if (w_ack_ok) begin
              r_retry <= '0;
              r_state <= S_NEXT;
            end else if (r_retry < c_RETRIES) begin
              r_retry <= r_retry + RW'(1);
              r_state <= S_SEND;
            end else begin
              err_o      <= 1'b1;
              fail_idx_o <= rom_addr_o;
              fail_cnt_o <= w_fail_cnt_inc;
              r_retry    <= '0;
              r_state    <= (STOP_ON_ERR != 0) ? S_FIN : S_NEXT;
            end
            if (abort_i || r_abort_pend) begin
              err_o   <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_DLY: begin
          if (abort_i) begin
            err_o   <= 1'b1;
            r_state <= S_FIN;
          end else if (r_dly <= c_DLY_ONE) begin
            r_state <= S_NEXT;
          end else begin
            r_dly <= r_dly - c_DLY_ONE;
          end
        end
        S_NEXT: begin
          if (abort_i) begin
            err_o   <= 1'b1;
            r_state <= S_FIN;
          end else if (rom_addr_o == c_LAST_ADDR) begin
            r_state <= S_FIN;
          end else begin
            rom_addr_o <= rom_addr_o + AW'(1);
            r_state    <= S_FETCH;
          end
        end
        S_FIN: begin
          busy_o       <= 1'b0;
          done_o       <= 1'b1;
          r_abort_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_seq_controller
// Function : Self-checking bench for i2c_seq_controller: ROM + I2C engine
//            models, sequence-level reference model, directed and random runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_seq_controller;

  localparam int NB  = 4;
  localparam int NT  = 8;
  localparam int RET = 3;
  localparam int SOE = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  rom_addr;
  logic [39:0] rom_data;
  logic        eng_send;
  logic [2:0]  eng_nbytes;
  logic [31:0] eng_data;
  logic        eng_ready;
  logic        eng_done;
  logic [3:0]  eng_ack;
  logic        busy, done, err;
  logic [2:0]  fail_idx;
  logic [7:0]  fail_cnt;

  i2c_seq_controller #(
    .NBYTES_MAX(NB), .NTRANS(NT), .RETRIES(RET), .DELAY_W(16),
    .ROM_LAT(1), .STOP_ON_ERR(SOE)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_1cc_i(start), .abort_i(abort),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .eng_send_o(eng_send), .eng_nbytes_o(eng_nbytes), .eng_data_o(eng_data),
    .eng_ready_i(eng_ready), .eng_done_i(eng_done), .eng_ack_i(eng_ack),
    .busy_o(busy), .done_o(done), .err_o(err),
    .fail_idx_o(fail_idx), .fail_cnt_o(fail_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Command ROM with one cycle read latency
  logic [39:0] rom [NT];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int          plan [NT];   // NACKed attempts before an ACK for each entry
  int          att  [NT];
  logic [31:0] act_d[$];
  int          act_n[$];
  int          send_cyc[$];
  int          done_cyc[$];
  logic [31:0] exp_d[$];
  int          exp_n[$];
  bit          exp_err;
  int          exp_idx, exp_cnt;
  int          st_cyc;

  bit          eng_busy = 1'b0;
  int          eng_left;
  int          lat_min = 1, lat_max = 4;
  bit          rdy_rand = 1'b0;
  int          cur_addr, cur_nb;
  logic [3:0]  e_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // I2C engine model: accepts strobes, answers after a random latency with scripted ACK/NACK
  initial begin
    eng_ready = 1'b1; eng_done = 1'b0; eng_ack = 4'h0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (eng_busy) begin
        chk("send_while_busy", {63'd0, eng_send}, 64'd0);
        eng_left--;
        if (eng_left <= 0) begin
          e_ack = 4'($urandom) | 4'((1 << cur_nb) - 1);
          if (att[cur_addr] < plan[cur_addr])
            e_ack[$urandom_range(0, cur_nb - 1)] = 1'b0;
          att[cur_addr]++;
          eng_ack   = e_ack;
          eng_done  = 1'b1;
          eng_busy  = 1'b0;
          eng_ready = 1'b1;
          done_cyc.push_back(cyc);
        end
      end else if (eng_send) begin
        chk("send_while_ready", {63'd0, eng_ready}, 64'd1);
        act_d.push_back(eng_data);
        act_n.push_back(int'(eng_nbytes));
        send_cyc.push_back(cyc);
        cur_addr  = int'(rom_addr);
        cur_nb    = int'(eng_nbytes);
        eng_busy  = 1'b1;
        eng_left  = $urandom_range(lat_min, lat_max);
        eng_ready = 1'b0;
      end else begin
        eng_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  function automatic logic [39:0] wr(input int nb, input logic [31:0] p);
    return {4'b0000, 4'(nb), p};
  endfunction
  function automatic logic [39:0] dl(input int n);
    return {8'h40, 16'($urandom), 16'(n)};
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < NT; a++) begin
      rom[a]  = {8'h80, 32'h0};
      plan[a] = 0;
    end
  endtask

  // Reference model: walk the ROM by the sequencer's rules and list the expected transfers
  function automatic void model();
    exp_d.delete(); exp_n.delete();
    exp_err = 1'b0; exp_idx = 0; exp_cnt = 0;
    for (int a = 0; a < NT; a++) begin
      logic [7:0] c = rom[a][39:32];
      int nb = int'(c[3:0]);
      bit fl = 1'b0;
      bit stop = 1'b0;
      case (c[7:6])
        2'b00: begin
          if (nb < 1 || nb > NB) fl = 1'b1;
          else begin
            int n = (plan[a] > RET) ? RET + 1 : plan[a] + 1;
            for (int k = 0; k < n; k++) begin
              exp_d.push_back(rom[a][31:0]);
              exp_n.push_back(nb);
            end
            if (plan[a] > RET) fl = 1'b1;
          end
        end
        2'b01: ;
        2'b10: stop = 1'b1;
        default: begin fl = 1'b1; stop = 1'b1; end
      endcase
      if (fl) begin
        exp_err = 1'b1; exp_idx = a; exp_cnt++;
        if (SOE != 0) stop = 1'b1;
      end
      if (stop) break;
    end
  endfunction

  task automatic clear_obs();
    act_d.delete(); act_n.delete(); send_cyc.delete(); done_cyc.delete();
    for (int a = 0; a < NT; a++) att[a] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit poke);
    for (int i = 0; i < budget && !(!busy && done); i++) begin
      start = (poke && i == 5 && busy);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_finished"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run(input string tag, input int budget, input bit poke);
    clear_obs();
    model();
    pulse_start();
    wait_done(tag, budget, poke);
    chk({tag, "_nsend"}, 64'(act_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
      chk({tag, "_data"}, 64'(act_d[i]), 64'(exp_d[i]));
      chk({tag, "_nbytes"}, 64'(act_n[i]), 64'(exp_n[i]));
    end
    chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
    chk({tag, "_fcnt"}, 64'(fail_cnt), 64'(exp_cnt));
    chk({tag, "_fidx"}, 64'(fail_idx), 64'(exp_idx));
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_send(input string tag, input int budget);
    for (int i = 0; i < budget && act_d.size() == 0; i++) @(negedge clk);
    chk({tag, "_saw_send"}, 64'(act_d.size()), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();
    clear_obs();
    repeat (3) @(negedge clk);
    chk("reset_state", {11'd0, busy, done, err, fail_cnt, fail_idx, eng_send,
                        rom_addr, eng_nbytes, eng_data}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 3-byte write then END
    clear_rom();
    rom[0] = wr(3, 32'h72083500);
    run("t1", 200, 1'b0);
    chk("t1_latency", 64'(send_cyc[0] - st_cyc), 64'd4);
    chk("t1_payload", 64'(eng_data), 64'h72083500);

    // Two NACKs then ACK: three identical sends
    clear_rom();
    rom[0]  = wr(2, 32'hA55A1234);
    plan[0] = 2;
    run("t2", 300, 1'b0);
    chk("t2_sends", 64'(act_d.size()), 64'd3);

    // Entry 5 exhausts retries, skipped; no END so the sequence stops at the last entry
    clear_rom();
    for (int a = 0; a < NT; a++) rom[a] = wr(1 + a % 4, $urandom);
    plan[5] = 255;
    run("t3", 1000, 1'b1);
    chk("t3_fidx5", 64'(fail_idx), 64'd5);

    // Inter-command delays: none, 1000 and 0 cycles
    clear_rom();
    rdy_rand = 1'b0;
    rom[0] = wr(1, 32'h11000000);
    rom[1] = wr(1, 32'h22000000);
    rom[2] = dl(1000);
    rom[3] = wr(2, 32'h33440000);
    rom[4] = dl(0);
    rom[5] = wr(1, 32'h55000000);
    run("t4", 5000, 1'b0);
    if (send_cyc.size() == 4 && done_cyc.size() >= 3) begin
      chk("t4_gap_none", 64'(send_cyc[1] - done_cyc[0]), 64'd5);
      chk("t4_gap_1000", 64'(send_cyc[2] - done_cyc[1]), 64'd1008);
      chk("t4_gap_0",    64'(send_cyc[3] - done_cyc[2]), 64'd9);
    end else begin
      chk("t4_send_count", 64'(send_cyc.size()), 64'd4);
    end

    // Abort raised during WAIT: transfer completes, nothing further is sent
    clear_rom();
    for (int a = 0; a < NT; a++) rom[a] = wr(1, $urandom);
    lat_min = 20; lat_max = 20;
    clear_obs();
    pulse_start();
    wait_send("t6", 100);
    abort = 1'b1;
    wait_done("t6", 200, 1'b0);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_nsend", 64'(act_d.size()), 64'd1);
    chk("t6_err", {63'd0, err}, 64'd1);
    chk("t6_fcnt", 64'(fail_cnt), 64'd0);

    // Asynchronous reset in the middle of a transfer
    clear_rom();
    rom[0] = wr(0, 32'h0);
    rom[1] = wr(4, 32'hDEADBEEF);
    clear_obs();
    pulse_start();
    wait_send("t7", 100);
    #2 rst_n = 1'b0;
    #1 chk("t7_async_rst", {11'd0, busy, done, err, fail_cnt, fail_idx, eng_send,
                            rom_addr, eng_nbytes, eng_data}, 64'd0);
    eng_busy = 1'b0; eng_done = 1'b0; eng_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    lat_min = 1; lat_max = 4;
    repeat (2) @(negedge clk);

    // Random ROM images, random engine readiness and latency, stray starts while busy
    rdy_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      clear_rom();
      for (int a = 0; a < NT; a++) begin
        int sel = $urandom_range(0, 15);
        if (sel <= 8 || sel >= 14) rom[a] = wr($urandom_range(1, NB), $urandom);
        else if (sel <= 10)        rom[a] = dl($urandom_range(0, 15));
        else if (sel == 11)        rom[a] = wr(($urandom_range(0, 1) != 0) ? 0 : $urandom_range(NB + 1, 15), $urandom);
        else if (sel == 12)        rom[a] = {8'h80, 32'($urandom)};
        else                       rom[a] = {8'hC0, 32'($urandom)};
        plan[a] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      end
      run("rnd", 3000, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_seq_controller.md
Name: i2c_seq_controller

Overview:
- Command-driven I2C configuration sequencer.
- Fetches entries from a synchronous command ROM and drives the existing byte-level I2C engine through a send/done handshake.
- Each entry is a WRITE of 1..NBYTES_MAX bytes, a DELAY, or an END.
- Adds bounded per-entry retry on NACK, programmable inter-command delays, abort, and failure reporting, so one block replaces fixed-length, fixed-byte-count init sequencers (e.g. HDMI transmitter bring-up).

Parameters:
- NBYTES_MAX, 4, max bytes per WRITE entry (1..8).
- NTRANS, 64, ROM depth in entries.
- RETRIES, 3, retry attempts after a NACKed WRITE (0 = no retry).
- DELAY_W, 16, width of the DELAY cycle count.
- ROM_LAT, 1, ROM read latency in cycles (1 or 2).
- STOP_ON_ERR, 0, 1 = finish the sequence at the first exhausted entry; 0 = skip that entry and continue.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_1cc_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- abort_i  in  1  level; ends the sequence early.
- rom_addr_o  out  clog2(NTRANS)  ROM entry address.
- rom_data_i  in  8+8*NBYTES_MAX  entry data: {ctrl[7:0], payload}.
- eng_send_o  out  1  one-cycle send strobe to the I2C engine.
- eng_nbytes_o  out  clog2(NBYTES_MAX+1)  byte count for the transfer.
- eng_data_o  out  8*NBYTES_MAX  payload; byte 0 in the MSBs, sent first.
- eng_ready_i  in  1  engine idle and able to accept send.
- eng_done_i  in  1  one-cycle pulse when the transfer completes.
- eng_ack_i  in  NBYTES_MAX  per-byte ACK flags; valid with eng_done_i.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence finished; held until the next accepted start.
- err_o  out  1  sticky: some entry failed, or the sequence was aborted.
- fail_idx_o  out  clog2(NTRANS)  address of the last failed entry.
- fail_cnt_o  out  8  count of failed entries; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; all outputs 0; retry count 0; delay counter 0.
- ctrl[7:6] is the opcode: 00 WRITE, 01 DELAY, 10 END, 11 illegal.
  - WRITE: nbytes = ctrl[3:0].
  - DELAY: cycle count = payload[DELAY_W-1:0].
- IDLE: on start_1cc_i, clear rom_addr_o, done_o, err_o, fail_cnt_o and fail_idx_o; busy_o=1; go to FETCH.
- FETCH: hold rom_addr_o for exactly ROM_LAT cycles, then go to DECODE, which samples rom_data_i.
- DECODE:
  - WRITE with 1 <= nbytes <= NBYTES_MAX: latch eng_nbytes_o and eng_data_o; go to SEND.
  - WRITE with nbytes=0 or nbytes > NBYTES_MAX: treat as a failed entry (see failure); no I2C traffic.
  - DELAY: load the counter; go to DLY.
  - END: go to FIN.
  - Illegal opcode: failure, then FIN regardless of STOP_ON_ERR.
- SEND: wait for eng_ready_i=1, then pulse eng_send_o for one cycle and go to WAIT. The strobe never fires while eng_ready_i=0.
- WAIT: on eng_done_i, compute success = AND of eng_ack_i[nbytes-1:0]; upper bits are ignored.
  - Success: clear retry count; go to NEXT.
  - NACK with retry count < RETRIES: increment the count; return to SEND with eng_data_o and eng_nbytes_o unchanged (no refetch).
  - NACK with retries exhausted: failure.
- Failure:
  - err_o <= 1; fail_idx_o <= rom_addr_o; fail_cnt_o increments, saturating at 255; retry count cleared.
  - If STOP_ON_ERR=1, go to FIN; otherwise go to NEXT.
- DLY: decrement each cycle; leave for NEXT when the count reaches 0. A count of 0 takes exactly 1 cycle in DLY.
- NEXT:
  - If rom_addr_o == NTRANS-1, go to FIN (implicit end; no wrap).
  - Otherwise rom_addr_o <= rom_addr_o+1; go to FETCH.
- FIN: busy_o <= 0; done_o <= 1; go to IDLE. done_o stays 1 until the next accepted start.
- abort_i=1:
  - In FETCH, DECODE, SEND (before the strobe), DLY or NEXT: go to FIN next cycle; err_o <= 1.
  - In WAIT: finish the in-flight transfer. On eng_done_i go to FIN with err_o <= 1; this does not count toward fail_cnt_o.
  - In IDLE: no effect.
- start_1cc_i while busy_o=1 is ignored. Start in the same cycle FIN completes is also ignored; start is accepted only in IDLE.
- Simultaneous eng_done_i and abort_i in WAIT: record the transfer result (success or failure), then go to FIN.
- Latency, single-entry WRITE with ROM_LAT=1 and engine ready: start to eng_send_o = 4 cycles (IDLE→FETCH→DECODE→SEND strobe).

Test Plan:
- ROM = {WRITE 3 bytes 72 08 35, END}; engine ACKs all -> one send, eng_nbytes_o=3, eng_data_o MSBs=72_08_35, done_o=1, err_o=0, fail_cnt_o=0.
- WRITE 2 bytes NACKed 2 times then ACKed, RETRIES=3 -> exactly 3 eng_send_o pulses with identical data; err_o=0.
- WRITE always NACKed on byte 1, RETRIES=3, STOP_ON_ERR=0, at entry 5 followed by 2 good WRITEs -> 4 sends for entry 5, fail_idx_o=5, fail_cnt_o=1, err_o=1; later entries are sent; done_o=1.
- DELAY 1000 between two WRITEs -> exactly 1000 cycles in DLY (DLY entry to NEXT) between the WAIT completion and the next FETCH; DELAY 0 -> 1 cycle.
- NTRANS=4 with no END entry -> 4 entries executed, rom_addr_o never exceeds 3, done_o=1; a start while busy is ignored.
- abort_i raised mid-WAIT -> no further sends after eng_done_i; done_o=1, err_o=1; asynchronous reset mid-WAIT -> all outputs 0 immediately.
